fetch_queue: RTL and testbench



---
 rtl/fetch_queue.sv | 156 +++++++++++++++
 tb/tb_fetch_queue.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: decoupled instruction-fetch front end.
//   Owns the fetch PC and issues one-outstanding requests on the instruction
//   bus. Returned instructions go into a DEPTH-entry FIFO that the decode stage
//   drains with valid/ready. A redirect flushes the FIFO and restarts fetch,
//   discarding any response still in flight.
// Ports:
//   clk, reset (async, active-low)
//   ireq_valid/ireq_addr         : instruction bus request (held until data_ok)
//   iresp_data_ok/iresp_data     : bus response, completes the current request
//   redirect_valid/redirect_pc   : flush and restart fetch at redirect_pc
//   out_valid/out_ready          : decode handshake for the FIFO head
//   out_pc/out_instr/out_fault   : head entry (fault = misaligned fetch PC)
// Optional feature macro: FETCH_QUEUE_BYPASS_EN (same-cycle response bypass
//   into out_* when the FIFO is empty).
module fetch_queue #(
  parameter int unsigned        DEPTH    = 4,
  parameter int unsigned        ADDR_W   = 64,
  parameter int unsigned        INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(64'h8000_0000)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               ireq_valid,
  output logic [ADDR_W-1:0]  ireq_addr,
  input  logic               iresp_data_ok,
  input  logic [INSTR_W-1:0] iresp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic               out_fault
);

  localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned      CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, KILL, HALT} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
    logic               fault;
  } entry_t;

  state_t             state, state_next;
  logic [ADDR_W-1:0]  fetch_pc, pc_next;
  logic [ADDR_W-1:0]  req_addr;
  logic [CNT_W-1:0]   count, count_after;
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  entry_t             mem [DEPTH];

  logic               has_room, pc_aligned;
  logic               resp_take, fault_push, push, write, pop;
  logic               bypass, bypass_take;
  entry_t             resp_entry, fault_entry, push_entry, head;

  // Queue-side decode shared by the FSM and the datapath
  assign has_room    = (count < FULL_CNT);
  assign pc_aligned  = (fetch_pc[1:0] == 2'b00);
  assign resp_take   = (state == BUSY) && iresp_data_ok;
  assign fault_push  = (state == IDLE) && has_room && !pc_aligned;
  assign push        = resp_take || fault_push;

  always_comb begin
    resp_entry  = '{pc: fetch_pc, instr: iresp_data, fault: 1'b0};
    fault_entry = '{pc: fetch_pc, instr: '0, fault: 1'b1};
    push_entry  = fault_push ? fault_entry : resp_entry;
  end

`ifdef FETCH_QUEUE_BYPASS_EN
  // Empty queue: present the live response directly to decode
  assign bypass = resp_take && !redirect_valid && (count == '0);
  assign head   = bypass ? resp_entry : mem[rd_ptr];
`else
  assign bypass = 1'b0;
  assign head   = mem[rd_ptr];
`endif

  assign bypass_take = bypass && out_ready;
  assign pop         = out_ready && (count != '0);
  assign write       = push && !bypass_take;
  assign count_after = count + CNT_W'(write) - CNT_W'(pop);

  assign out_valid  = (count != '0) || bypass;
  assign out_pc     = head.pc;
  assign out_instr  = head.instr;
  assign out_fault  = head.fault;

  assign ireq_valid = (state == BUSY) || (state == KILL);
  assign ireq_addr  = req_addr;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and next fetch PC; redirect overrides everything
  always_comb begin
    state_next = state;
    pc_next    = fetch_pc;
    case (state)
      IDLE: if (has_room) state_next = pc_aligned ? BUSY : HALT;
      BUSY: if (iresp_data_ok) begin
              pc_next    = fetch_pc + ADDR_W'(4);
              state_next = ((count_after < FULL_CNT) && (pc_next[1:0] == 2'b00)) ? BUSY : IDLE;
            end
      KILL: if (iresp_data_ok) state_next = IDLE;
      HALT: state_next = HALT;
      default: state_next = IDLE;
    endcase
    if (redirect_valid) begin
      pc_next = redirect_pc;
      if (((state == BUSY) || (state == KILL)) && !iresp_data_ok) state_next = KILL;
      else                                                        state_next = IDLE;
    end
  end

  // Fetch PC and bus address. The bus address is a separate register so an
  // outstanding request keeps its address while fetch_pc already holds a
  // redirect target (KILL).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      fetch_pc <= pc_next;
      if (!(ireq_valid && !iresp_data_ok)) req_addr <= pc_next;
    end
  end

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (redirect_valid) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (write) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_after;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
`timescale 1ns/1ps
module tb_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned ADDR_W   = 64;
  localparam int unsigned INSTR_W  = 32;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk, reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_fault;

  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_fault(out_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  // Reference model: expected entries in decode order, next expected fetch PC,
  // whether fetch is halted on a fault, whether the open bus transaction was
  // orphaned by a redirect.
  exp_t        exp_q[$];
  logic [63:0] exp_pc;
  logic        halted, txn_killed;
  logic        prev_valid, prev_dok;
  logic [63:0] prev_addr;
  int          req_count;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    exp_q.delete();
    exp_pc     = RESET_PC;
    halted     = 1'b0;
    txn_killed = 1'b0;
    prev_valid = 1'b0;
    prev_dok   = 1'b0;
    prev_addr  = '0;
  endtask

  // Decoupled monitor: each accepted head is compared to the oldest expectation
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 64'(out_valid), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_pc", out_pc, e.pc);
        check("out_instr", 64'(out_instr), 64'(e.instr));
        check("out_fault", 64'(out_fault), 64'(e.fault));
      end
    end
  end

  // Drive one cycle of inputs (called just after a rising edge) and update the model
  task automatic drive(input logic dok_req, input logic [31:0] d, input logic rv,
                       input logic [63:0] rpc, input logic rdy);
    logic dok;
    dok = dok_req && ireq_valid;
    if (prev_valid && !prev_dok && ireq_valid) check("addr_hold", ireq_addr, prev_addr);
    if (halted && !txn_killed) check("halt_noreq", 64'(ireq_valid), 64'd0);
    if (dok) begin
      req_count++;
      if (!txn_killed && !rv) begin
        check("req_addr", ireq_addr, exp_pc);
        exp_q.push_back('{pc: exp_pc, instr: d, fault: 1'b0});
        exp_pc = exp_pc + 64'd4;
      end
      txn_killed = 1'b0;
    end else if (rv && ireq_valid) begin
      txn_killed = 1'b1;
    end
    if (rv) begin
      exp_q.delete();
      exp_pc = rpc;
      halted = (rpc[1:0] != 2'b00);
      if (halted) exp_q.push_back('{pc: rpc, instr: 32'd0, fault: 1'b1});
    end
    prev_valid     = ireq_valid;
    prev_dok       = dok;
    prev_addr      = ireq_addr;
    iresp_data_ok  = dok;
    iresp_data     = d;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy && !rv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic dok_req, input logic [31:0] d, input logic rv,
                       input logic [63:0] rpc, input logic rdy);
    drive(dok_req, d, rv, rpc, rdy);
    tick();
  endtask

  initial begin
    reset = 1'b0;
    iresp_data_ok = 1'b0; iresp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0;
    out_ready = 1'b0;
    req_count = 0;
    reset_model();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ireq_valid", 64'(ireq_valid), 64'd0);
    check("rst_ireq_addr", ireq_addr, RESET_PC);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_pc", out_pc, 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_out_fault", 64'(out_fault), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Back-to-back streaming, latency from response to head
    for (int i = 0; i < 8; i++) begin
      check("stream_valid", 64'(ireq_valid), 64'd1);
      drive(1'b1, 32'h0000_0013, 1'b0, 64'd0, 1'b1);
      #1;
      if (i == 0) check("lat_same_cycle", 64'(out_valid), 64'(BYP));
      tick();
      if (i == 0) check("lat_next_cycle", 64'(out_valid), 64'd1);
    end
    drive(1'b0, 32'd0, 1'b0, 64'd0, 1'b1);
    #1;
    check("stream_occupancy", 64'(out_valid), BYP ? 64'd0 : 64'd1);
    tick();

    // PC wrap at the top of the address space
    cycle(1'b0, 32'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1, $urandom, 1'b0, 64'd0, 1'b1);

    // Backpressure: queue fills, fetch stalls, one pop frees one request
    cycle(1'b0, 32'd0, 1'b1, 64'h8000_2000, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, $urandom, 1'b0, 64'd0, 1'b0);
    check("bp_stall", 64'(ireq_valid), 64'd0);
    check("bp_full_valid", 64'(out_valid), 64'd1);
    req_count = 0;
    cycle(1'b0, 32'd0, 1'b0, 64'd0, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b1, $urandom, 1'b0, 64'd0, 1'b0);
    check("bp_single_req", 64'(req_count), 64'd1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'd0, 1'b0, 64'd0, 1'b1);

    // Redirect during an outstanding request whose response is delayed
    check("kill_pre_valid", 64'(ireq_valid), 64'd1);
    cycle(1'b0, 32'd0, 1'b1, 64'h8000_1000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("kill_hold_valid", 64'(ireq_valid), 64'd1);
      check("kill_hold_addr", ireq_addr, 64'h8000_2014);
      check("kill_out_valid", 64'(out_valid), 64'd0);
      cycle(1'b0, 32'd0, 1'b0, 64'd0, 1'b1);
    end
    cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 64'd0, 1'b1);
    check("kill_gap_valid", 64'(ireq_valid), 64'd0);
    check("kill_gap_out", 64'(out_valid), 64'd0);
    cycle(1'b0, 32'd0, 1'b0, 64'd0, 1'b1);
    check("kill_new_valid", 64'(ireq_valid), 64'd1);
    check("kill_new_addr", ireq_addr, 64'h8000_1000);
    check("kill_new_out", 64'(out_valid), 64'd0);
    for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1'b0, 64'd0, 1'b1);

    // Redirect and response in the same cycle; new request two cycles later
    cycle(1'b1, 32'h0000_1234, 1'b1, 64'h8000_3000, 1'b0);
    check("same_t1_out", 64'(out_valid), 64'd0);
    check("same_t1_req", 64'(ireq_valid), 64'd0);
    cycle(1'b0, 32'd0, 1'b0, 64'd0, 1'b1);
    check("same_t2_req", 64'(ireq_valid), 64'd1);
    check("same_t2_addr", ireq_addr, 64'h8000_3000);
    for (int i = 0; i < 2; i++) cycle(1'b1, $urandom, 1'b0, 64'd0, 1'b1);

    // Misaligned redirect: one fault entry, then fetch stays halted
    cycle(1'b1, $urandom, 1'b1, 64'h8000_0002, 1'b0);
    check("mis_t1_req", 64'(ireq_valid), 64'd0);
    cycle(1'b0, 32'd0, 1'b0, 64'd0, 1'b0);
    check("mis_valid", 64'(out_valid), 64'd1);
    check("mis_pc", out_pc, 64'h8000_0002);
    check("mis_instr", 64'(out_instr), 64'd0);
    check("mis_fault", 64'(out_fault), 64'd1);
    cycle(1'b1, $urandom, 1'b0, 64'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("halt_out_valid", 64'(out_valid), 64'd0);
      check("halt_req_valid", 64'(ireq_valid), 64'd0);
      cycle(1'b1, $urandom, 1'b0, 64'd0, 1'b1);
    end
    cycle(1'b0, 32'd0, 1'b1, 64'h8000_0100, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic        rv;
      logic [63:0] rpc;
      rv  = ($urandom_range(0, 31) == 0);
      rpc = 64'h8000_0000 + 64'($urandom_range(0, 255)) * 64'd4;
      if ($urandom_range(0, 7) == 0) rpc = rpc + 64'($urandom_range(1, 3));
      cycle(1'($urandom_range(0, 1)), $urandom, rv, rpc, ($urandom_range(0, 3) != 0));
    end

    // Reset in the middle of an outstanding request
    cycle(1'b0, 32'd0, 1'b1, 64'h8000_4000, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 64'd0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 64'd0, 1'b1);
    check("mid_pre_req", 64'(ireq_valid), 64'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_req", 64'(ireq_valid), 64'd0);
    check("mid_rst_addr", ireq_addr, RESET_PC);
    check("mid_rst_out", 64'(out_valid), 64'd0);
    reset_model();
    iresp_data_ok = 1'b1; iresp_data = 32'hBAD0_BAD0;
    redirect_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("mid_rst_nocap", 64'(out_valid), 64'd0);
    iresp_data_ok = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) cycle(1'b1, $urandom, 1'b0, 64'd0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b0, 64'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
